// File: rtl/mac_rx_ingress.sv
// Receive-side frame consumer: pops one pointer per frame, drops errored/short frames,
// and forwards good frames minus FCS over a valid/ready byte stream with header capture.
module mac_rx_ingress (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ptr_fifo_empty,
    output logic        ptr_fifo_rd,
    input  logic [15:0] ptr_fifo_dout,
    output logic        data_fifo_rd,
    input  logic [7:0]  data_fifo_dout,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_sof,
    output logic        o_eof,
    input  logic        o_ready,
    output logic [47:0] da,
    output logic [47:0] sa,
    output logic        hdr_valid,
    output logic [15:0] good_cnt,
    output logic [15:0] drop_crc_cnt,
    output logic [15:0] drop_len_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_PTR_LAT, S_FWD, S_SKIP_FCS, S_DISCARD} state_t;

    state_t      r_state, w_state_next;
    logic        r_run;
    logic [11:0] r_remain, w_remain_next;
    logic [11:0] r_fwd_len, r_widx;
    logic        r_inflight_fwd;
    logic [1:0]  r_cnt;
    logic [9:0]  r_head, r_skid, w_in;
    logic [47:0] r_da, r_sa;
    logic        r_hdr_valid;
    logic [15:0] r_good_cnt, r_crc_cnt, r_len_cnt;
    logic        w_good_inc, w_crc_inc, w_len_inc;
    logic        w_pop, w_push, w_fwd_space, w_unused;
    logic [11:0] w_len;
    logic [2:0]  w_occ_after;

    assign w_len       = ptr_fifo_dout[11:0];
    assign w_unused    = ^ptr_fifo_dout[13:12];
    assign o_valid     = (r_cnt != 2'd0);
    assign w_pop       = o_valid & o_ready;
    assign w_push      = r_inflight_fwd;
    // Occupancy the buffer will have once this cycle's pop and in-flight byte settle
    assign w_occ_after = {1'b0, r_cnt} - {2'b00, w_pop} + {2'b00, r_inflight_fwd};
    assign w_fwd_space = (w_occ_after < 3'd2);
    assign w_in        = {(r_widx == 12'd0), (r_widx == r_fwd_len - 12'd1), data_fifo_dout};

    always_comb begin
        w_state_next  = r_state;
        w_remain_next = r_remain;
        ptr_fifo_rd   = 1'b0;
        data_fifo_rd  = 1'b0;
        w_good_inc    = 1'b0;
        w_crc_inc     = 1'b0;
        w_len_inc     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_run && !ptr_fifo_empty) begin
                    ptr_fifo_rd  = 1'b1;
                    w_state_next = S_PTR_LAT;
                end
            end
            S_PTR_LAT: begin
                if (ptr_fifo_dout[15] || ptr_fifo_dout[14] || (w_len <= 12'd4)) begin
                    w_crc_inc     = ptr_fifo_dout[15];
                    w_len_inc     = !ptr_fifo_dout[15];
                    w_remain_next = w_len;
                    w_state_next  = (w_len == 12'd0) ? S_IDLE : S_DISCARD;
                end else begin
                    w_good_inc    = 1'b1;
                    w_remain_next = w_len - 12'd4;
                    w_state_next  = S_FWD;
                end
            end
            S_FWD: begin
                if (w_fwd_space) begin
                    data_fifo_rd  = 1'b1;
                    w_remain_next = r_remain - 12'd1;
                    if (r_remain == 12'd1) begin
                        w_remain_next = 12'd4;
                        w_state_next  = S_SKIP_FCS;
                    end
                end
            end
            S_SKIP_FCS, S_DISCARD: begin
                data_fifo_rd  = 1'b1;
                w_remain_next = r_remain - 12'd1;
                if (r_remain == 12'd1) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_remain       <= 12'd0;
            r_run          <= 1'b0;
            r_inflight_fwd <= 1'b0;
            r_hdr_valid    <= 1'b0;
            r_fwd_len      <= 12'd0;
            r_widx         <= 12'd0;
            r_da           <= 48'd0;
            r_sa           <= 48'd0;
            r_good_cnt     <= 16'd0;
            r_crc_cnt      <= 16'd0;
            r_len_cnt      <= 16'd0;
        end else begin
            r_state        <= w_state_next;
            r_remain       <= w_remain_next;
            r_run          <= 1'b1;
            r_inflight_fwd <= data_fifo_rd && (r_state == S_FWD);
            r_hdr_valid    <= w_push && (r_widx == 12'd11);
            if (w_good_inc) begin
                r_fwd_len <= w_len - 12'd4;
                r_widx    <= 12'd0;
            end else if (w_push) begin
                r_widx <= r_widx + 12'd1;
            end
            if (w_push && (r_widx < 12'd6)) begin
                r_da <= {r_da[39:0], data_fifo_dout};
            end else if (w_push && (r_widx < 12'd12)) begin
                r_sa <= {r_sa[39:0], data_fifo_dout};
            end
            if (w_good_inc && (r_good_cnt != 16'hFFFF)) r_good_cnt <= r_good_cnt + 16'd1;
            if (w_crc_inc && (r_crc_cnt != 16'hFFFF))   r_crc_cnt  <= r_crc_cnt + 16'd1;
            if (w_len_inc && (r_len_cnt != 16'hFFFF))   r_len_cnt  <= r_len_cnt + 16'd1;
        end
    end

    // Two-entry output buffer: head drives the outputs, skid absorbs one byte of backpressure
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt  <= 2'd0;
            r_head <= 10'd0;
            r_skid <= 10'd0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_push) begin
                        r_head <= w_in;
                        r_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= w_in;
                    end else if (w_push) begin
                        r_skid <= w_in;
                        r_cnt  <= 2'd2;
                    end else if (w_pop) begin
                        r_cnt <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head <= r_skid;
                        if (w_push) r_skid <= w_in;
                        else        r_cnt  <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign o_data       = r_head[7:0];
    assign o_eof        = r_head[8];
    assign o_sof        = r_head[9];
    assign da           = r_da;
    assign sa           = r_sa;
    assign hdr_valid    = r_hdr_valid;
    assign good_cnt     = r_good_cnt;
    assign drop_crc_cnt = r_crc_cnt;
    assign drop_len_cnt = r_len_cnt;
endmodule

// File: doc/mac_rx_ingress.md
# mac_rx_ingress

Clk-domain consumer of a receive MAC's frame FIFO pair: pops one pointer word per frame, discards frames flagged with CRC or length errors, and streams good frames (FCS stripped) to the switch core over a valid/ready byte interface. It extracts destination/source MAC addresses for the forwarding lookup and keeps saturating per-port statistics. Sits between the per-port receive MAC (data FIFO 8-bit, pointer FIFO 16-bit, both with 1-cycle read latency) and the switch ingress arbiter.

## Interface
- No parameters; widths fixed.

- clk  in  1  system clock (FIFO read side)
- rstn  in  1  reset, asynchronous, active-low
- ptr_fifo_empty  in  1  pointer FIFO empty
- ptr_fifo_rd  out  1  pointer FIFO pop; dout valid next cycle
- ptr_fifo_dout  in  16  [15] CRC error, [14] length error, [11:0] byte count incl. FCS
- data_fifo_rd  out  1  data FIFO pop; dout valid next cycle
- data_fifo_dout  in  8  frame byte
- o_data  out  8  frame byte to core
- o_valid  out  1  o_data valid
- o_sof  out  1  first byte of frame (qualified by o_valid)
- o_eof  out  1  last byte of frame (qualified by o_valid)
- o_ready  in  1  core accepts byte when o_valid & o_ready
- da  out  48  destination MAC, byte 0 in [47:40]
- sa  out  48  source MAC, byte 6 in [47:40]
- hdr_valid  out  1  one-cycle pulse: da/sa complete
- good_cnt, drop_crc_cnt, drop_len_cnt  out  16 each  saturating frame counters

## Operation
- States: IDLE, PTR_LAT, FWD, SKIP_FCS, DISCARD.
- IDLE: if !ptr_fifo_empty, assert ptr_fifo_rd for exactly one cycle, go PTR_LAT.
- PTR_LAT: latch ptr_fifo_dout into len[11:0], err_crc, err_len. Decision:
  - err_crc=1 -> drop_crc_cnt++, DISCARD len bytes (CRC takes priority when both bits set).
  - else err_len=1 -> drop_len_cnt++, DISCARD len bytes.
  - else len<=4 -> treated as length error (drop_len_cnt++, DISCARD).
  - else good_cnt++, FWD with remaining = len-4.
  - len=0 in any drop path -> back to IDLE, no data reads.
- FWD: pop len-4 bytes into a 2-entry output buffer; a read is issued only when (buffer occupancy + reads in flight) < 2, so no byte is ever lost under backpressure. First byte tagged o_sof, byte len-5 tagged o_eof. After last FWD pop -> SKIP_FCS.
- SKIP_FCS: pop exactly 4 bytes unconditionally (one per cycle, ignore o_ready), not forwarded. Then IDLE once output buffer drains is not required; next pointer may be read immediately.
- DISCARD: pop exactly len bytes, one per cycle, nothing on o_*; then IDLE.
- Header capture: as forwarded bytes 0..11 enter the output buffer they are shifted into da (0..5) and sa (6..11); hdr_valid pulses the cycle byte 11 is written. da/sa hold until next frame's byte 0.
- Counters increment in PTR_LAT decision cycle; saturate at 16'hFFFF (no wrap).
- Total data bytes popped per pointer always equals len: FIFO pair stays aligned.

## Timing
- Reset values: ptr_fifo_rd=0, data_fifo_rd=0, o_valid=0, o_sof=0, o_eof=0, o_data=0, da=0, sa=0, hdr_valid=0, all counters 0, state IDLE, buffer empty.
- Pointer pop to first data pop: 2 cycles (rd cycle, PTR_LAT cycle, first data_fifo_rd on the following cycle).
- First data pop to o_valid: 2 cycles (FIFO latency + output register).
- With o_ready held high: 1 byte/cycle sustained, o_valid continuous for the frame.
- o_data/o_sof/o_eof stable while o_valid & !o_ready.
- Reset mid-frame: all state and buffer cleared immediately; FIFO realignment is the MAC reset's concern (both share rstn).

## Test plan
- Good frame ptr=16'h0040, bytes 0x00..0x3F, o_ready=1 -> 60 bytes 0x00..0x3B out, o_sof on 0x00, o_eof on 0x3B, da=48'h000102030405, sa=48'h060708090A0B, hdr_valid once, 64 data pops, good_cnt=1.
- CRC error ptr=16'h8040 -> 64 data pops, o_valid never high, drop_crc_cnt=1, good_cnt=0.
- Length error ptr=16'h4028, plus both bits 16'hC028 -> 40 pops each, drop_len_cnt=1 then drop_crc_cnt=1.
- Good 100-byte frame with o_ready toggling 1/0 every cycle -> 96 bytes in order, no duplicates/loss, data_fifo_rd never exceeds buffer space.
- Back-to-back: good, bad, good pointers queued -> second good frame's o_sof follows first's o_eof, counters 2/1/0, exactly sum(len) data pops.
- rstn asserted after 10 bytes of a frame -> all outputs return to reset values within the reset; after release, new pointer processed normally.
